bc_polinomio: RTL
=================

# bc_polinomio

Control block (BC) for the 16-bit polynomial datapath (BO). It sequences the BO's X/S/H registers, its three 4:1 operand multiplexers and the ALU operation select to evaluate resultado = a·x² + b·x + c, or a·x + b in linear mode, using Horner's method. It runs one evaluation per start request and reports busy/done. It sits beside the BO and drives every BO control input.

## Interface
Parameters:
- none (the encodings below are fixed).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request one evaluation; sampled only in IDLE.
- modo  in  1  0 = quadratic (a·x²+b·x+c), 1 = linear (a·x+b); latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; BO resultado is valid while high.
- m0  out  2  BO mu_0 select: 00 = zero, 01 = a, 10 = b, 11 = c.
- m1  out  2  ALU operand B select: 00 = mu_0, 01 = X, 10 = S, 11 = H.
- m2  out  2  ALU operand A select: 00 = X, 01 = mu_0, 10 = S, 11 = H.
- lx, ls, lh  out  1 each  BO register load enables for X, S and H.
- h  out  1  ALU operation: 0 = add, 1 = multiply (16-bit result, truncated mod 2^16).

## Operation
- States: IDLE, LOAD_X, MUL_AX, ADD_B, MUL_X, ADD_C, DONE. Use a registered state. Outputs are a combinational (Moore) decode of state and the latched modo.
- IDLE: all outputs 0. If start = 1, latch modo and go to LOAD_X. Otherwise stay in IDLE.
- LOAD_X: lx = 1. Go to MUL_AX.
- MUL_AX: m0 = 01, m2 = 01, m1 = 01, h = 1, lh = 1, so H ← a·x. Go to ADD_B.
- ADD_B: m0 = 10, m2 = 11, m1 = 00, h = 0, so the ALU computes H + b.
  - Quadratic: lh = 1, H ← H + b. Go to MUL_X.
  - Linear: ls = 1, S ← H + b. Go to DONE.
- MUL_X: m2 = 11, m1 = 01, h = 1, lh = 1, so H ← H·x. Go to ADD_C.
- ADD_C: m0 = 11, m2 = 11, m1 = 00, h = 0, ls = 1, so S ← H + c. Go to DONE.
- DONE: done = 1, all loads 0. Go to IDLE unconditionally.
- Exactly one of lx, ls, lh is high per non-IDLE/non-DONE state. Never assert two loads in the same cycle.
- Selects not listed for a state are driven 00, never X.
- start outside IDLE is ignored; no queuing.
- Arithmetic is fully in the BO. The controller performs no width handling; overflow wraps mod 2^16.

## Timing
- Reset (asynchronous, rst_n = 0): state = IDLE, latched modo = 0, busy = 0, done = 0, all m* = 00, lx = ls = lh = h = 0. Outputs take these values immediately, without waiting for a clock. BO register contents are not cleared by this block.
- Reset mid-evaluation aborts it. No done is produced, and the first evaluation after release starts from IDLE.
- Start accepted at edge N (state was IDLE and start = 1):
  - Quadratic: X written at edge N+1, H at N+2, N+3 and N+4, S at N+5. done is high from N+5 to N+6, then IDLE at N+6.
  - Linear: X at N+1, H at N+2, S at N+3. done is high from N+3 to N+4.
- Latency from start sample to done: 5 cycles (quadratic), 3 cycles (linear). Throughput with start held high: one result per 7 cycles (quadratic) or 5 cycles (linear), because IDLE lasts at least one cycle between runs.
- Input stability: x must be stable at edge N+1. a, b and c must be stable during the state that selects them (MUL_AX, ADD_B, ADD_C respectively). A changed modo after acceptance has no effect.
- busy rises the cycle after start is accepted and falls when the state returns to IDLE. It is high during DONE.

## Test plan
- Quadratic, integrated with BO: a = 2, b = 3, c = 4, x = 5, modo = 0, 1-cycle start pulse → done exactly 5 cycles after the start edge, resultado = 69, busy high for 6 cycles.
- Linear: a = 2, b = 3, x = 5, modo = 1 → done 3 cycles after start, resultado = 13. Check that H is never multiplied by x a second time (no MUL_X state visited).
- Per-state output check: compare m0/m1/m2/lx/ls/lh/h against the state list every cycle. Flag any cycle with more than one load high.
- start held high for 20 cycles in quadratic mode → done pulses at cycles 5, 12 and 19 relative to the first accept. start pulses while busy cause no extra runs.
- Reset mid-operation: assert rst_n = 0 asynchronously in MUL_X → all outputs 0 before the next edge, no done. After release, a new run with a = 1, b = 0, c = 7, x = 3 gives resultado = 16.
- Wrap-around: a = 256, b = 1, c = 2, x = 256, modo = 0 → resultado = 258 (a·x wraps to 0, then (0+1)·256 + 2 = 258).

Source files
------------

// File: rtl/bc_polinomio.sv
// Control block for the 16-bit polynomial datapath: sequences X/S/H loads,
// operand selects and ALU op to evaluate a*x^2+b*x+c (or a*x+b) by Horner.
module bc_polinomio (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       modo,
  output logic       busy,
  output logic       done,
  output logic [1:0] m0,
  output logic [1:0] m1,
  output logic [1:0] m2,
  output logic       lx,
  output logic       ls,
  output logic       lh,
  output logic       h
);

  localparam int unsigned SEL_W = 2;

  // mu_0 sources
  localparam logic [SEL_W-1:0] M0_ZERO = 2'b00;
  localparam logic [SEL_W-1:0] M0_A    = 2'b01;
  localparam logic [SEL_W-1:0] M0_B    = 2'b10;
  localparam logic [SEL_W-1:0] M0_C    = 2'b11;
  // ALU operand B sources
  localparam logic [SEL_W-1:0] M1_MU0  = 2'b00;
  localparam logic [SEL_W-1:0] M1_X    = 2'b01;
  // ALU operand A sources
  localparam logic [SEL_W-1:0] M2_X    = 2'b00;
  localparam logic [SEL_W-1:0] M2_MU0  = 2'b01;
  localparam logic [SEL_W-1:0] M2_H    = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_X = 3'd1,
    MUL_AX = 3'd2,
    ADD_B  = 3'd3,
    MUL_X  = 3'd4,
    ADD_C  = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t state_q, state_d;
  logic   modo_q;

  // State register and mode latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      modo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        modo_q <= modo;
      end
    end
  end

  // Next-state logic; linear mode skips MUL_X/ADD_C after ADD_B
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD_X;
      LOAD_X:  state_d = MUL_AX;
      MUL_AX:  state_d = ADD_B;
      ADD_B:   state_d = modo_q ? DONE : MUL_X;
      MUL_X:   state_d = ADD_C;
      ADD_C:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode of state and latched mode
  always_comb begin
    busy = 1'b1;
    done = 1'b0;
    m0   = M0_ZERO;
    m1   = M1_MU0;
    m2   = M2_X;
    lx   = 1'b0;
    ls   = 1'b0;
    lh   = 1'b0;
    h    = 1'b0;
    unique case (state_q)
      IDLE: busy = 1'b0;
      LOAD_X: lx = 1'b1;
      MUL_AX: begin
        m0 = M0_A;
        m2 = M2_MU0;
        m1 = M1_X;
        h  = 1'b1;
        lh = 1'b1;
      end
      ADD_B: begin
        m0 = M0_B;
        m2 = M2_H;
        m1 = M1_MU0;
        // Linear mode finishes here, so the sum goes straight to S
        if (modo_q) begin
          ls = 1'b1;
        end else begin
          lh = 1'b1;
        end
      end
      MUL_X: begin
        m2 = M2_H;
        m1 = M1_X;
        h  = 1'b1;
        lh = 1'b1;
      end
      ADD_C: begin
        m0 = M0_C;
        m2 = M2_H;
        m1 = M1_MU0;
        ls = 1'b1;
      end
      DONE: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule
